// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and the
// fetch-to-decode handshake. The master modport is the fetch unit side.
interface fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        f_valid_o;
   logic [31:0] f_pc_o;
   logic [31:0] f_instr_o;
   logic        d_ready_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i,
      output f_valid_o,
      output f_pc_o,
      output f_instr_o,
      input  d_ready_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i,
      input  f_valid_o,
      input  f_pc_o,
      input  f_instr_o,
      output d_ready_i
   );
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests and buffers responses.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         redirect_i,
   input  logic [31:0]  redirect_pc_i,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]  perf_stall_cnt_o,
   output logic [31:0]  perf_flush_cnt_o,
`endif
   fetch_unit_if.master bus
);

   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   // Stale responses can pile up across back-to-back redirects on a slow memory.
   localparam int unsigned DropW = CntW + 4;
   localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

   typedef logic [PtrW-1:0] ptr_t;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   logic [31:0]      pc_q, pc_d;
   logic [CntW-1:0]  out_cnt_q, out_cnt_d;
   logic [DropW-1:0] drop_cnt_q, drop_cnt_d;

   logic [31:0]      ifq_pc_q [FIFO_DEPTH];
   ptr_t             ifq_wr_q, ifq_wr_d;
   ptr_t             ifq_rd_q, ifq_rd_d;

   logic [31:0]      rsp_pc_q    [FIFO_DEPTH];
   logic [31:0]      rsp_instr_q [FIFO_DEPTH];
   ptr_t             rsp_wr_q, rsp_wr_d;
   ptr_t             rsp_rd_q, rsp_rd_d;
   logic [CntW-1:0]  rsp_cnt_q, rsp_cnt_d;

   logic [CntW:0]    credit;
   logic             req;
   logic             grant;
   logic             drop_rsp;
   logic             live_rsp;
   logic             consumed_rsp;
   logic             f_valid;
   logic             pop;

   logic             unused_pc_lsb;
   assign unused_pc_lsb = ^redirect_pc_i[1:0];

   // Issue and handshake decode
   always_comb begin
      credit       = {1'b0, out_cnt_q} + {1'b0, rsp_cnt_q};
      req          = !rst_i && !redirect_i && (credit < DepthC);
      grant        = req && bus.imem_gnt_i;
      drop_rsp     = bus.imem_rvalid_i && (drop_cnt_q != '0);
      live_rsp     = bus.imem_rvalid_i && (drop_cnt_q == '0) && (out_cnt_q != '0);
      consumed_rsp = drop_rsp || live_rsp;
      f_valid      = rsp_cnt_q != '0;
      pop          = f_valid && bus.d_ready_i;
   end

   // Next-state for PC, credit counters and queue pointers
   always_comb begin
      pc_d       = pc_q;
      out_cnt_d  = out_cnt_q;
      drop_cnt_d = drop_cnt_q;
      ifq_wr_d   = ifq_wr_q;
      ifq_rd_d   = ifq_rd_q;
      rsp_wr_d   = rsp_wr_q;
      rsp_rd_d   = rsp_rd_q;
      rsp_cnt_d  = rsp_cnt_q;

      if (redirect_i) begin
         // Everything live becomes a pending discard, minus a response consumed right now.
         pc_d       = {redirect_pc_i[31:2], 2'b00};
         out_cnt_d  = '0;
         drop_cnt_d = drop_cnt_q + DropW'(out_cnt_q) - DropW'(consumed_rsp);
         ifq_wr_d   = '0;
         ifq_rd_d   = '0;
         rsp_wr_d   = '0;
         rsp_rd_d   = '0;
         rsp_cnt_d  = '0;
      end else begin
         if (grant) begin
            pc_d     = pc_q + 32'd4;
            ifq_wr_d = ptr_inc(ifq_wr_q);
         end
         if (drop_rsp) begin
            drop_cnt_d = drop_cnt_q - DropW'(1);
         end
         if (live_rsp) begin
            ifq_rd_d = ptr_inc(ifq_rd_q);
            rsp_wr_d = ptr_inc(rsp_wr_q);
         end
         if (pop) begin
            rsp_rd_d = ptr_inc(rsp_rd_q);
         end
         out_cnt_d = out_cnt_q + CntW'(grant) - CntW'(live_rsp);
         rsp_cnt_d = rsp_cnt_q + CntW'(live_rsp) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         ifq_wr_q   <= '0;
         ifq_rd_q   <= '0;
         rsp_wr_q   <= '0;
         rsp_rd_q   <= '0;
         rsp_cnt_q  <= '0;
      end else begin
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         ifq_wr_q   <= ifq_wr_d;
         ifq_rd_q   <= ifq_rd_d;
         rsp_wr_q   <= rsp_wr_d;
         rsp_rd_q   <= rsp_rd_d;
         rsp_cnt_q  <= rsp_cnt_d;
      end
   end

   // Queue storage needs no reset; occupancy is tracked by the pointers above.
   always_ff @(posedge clk_i) begin
      if (grant) begin
         ifq_pc_q[ifq_wr_q] <= pc_q;
      end
      if (live_rsp && !redirect_i) begin
         rsp_pc_q[rsp_wr_q]    <= ifq_pc_q[ifq_rd_q];
         rsp_instr_q[rsp_wr_q] <= bus.imem_rdata_i;
      end
   end

   always_comb begin
      bus.imem_req_o  = req;
      bus.imem_addr_o = pc_q;
      bus.f_valid_o   = f_valid;
      bus.f_pc_o      = f_valid ? rsp_pc_q[rsp_rd_q]    : 32'd0;
      bus.f_instr_o   = f_valid ? rsp_instr_q[rsp_rd_q] : 32'd0;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (f_valid && !bus.d_ready_i) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (redirect_i) begin
            flush_cnt_q <= flush_cnt_q + 32'(out_cnt_q) + 32'(rsp_cnt_q);
         end
      end
   end

   assign perf_stall_cnt_o = stall_cnt_q;
   assign perf_flush_cnt_o = flush_cnt_q;
`endif

   credit_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) credit <= DepthC);

   req_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (req && !bus.imem_gnt_i) |=>
         (redirect_i || (req && (bus.imem_addr_o == $past(bus.imem_addr_o)))));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction-memory model and a PC scoreboard.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;
`endif

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (3)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .redirect_i       (redirect),
      .redirect_pc_i    (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
      .perf_stall_cnt_o (perf_stall),
      .perf_flush_cnt_o (perf_flush),
`endif
      .bus              (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } mreq_t;

   mreq_t       mq[$];
   int          cyc = 0;
   int          last_ready = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          pops = 0;
   int          stall_tally = 0;
   int          flush_tally = 0;
   int          start;
   logic [31:0] exp_pc = RESET_PC;

   bit          gnt_on = 1'b1, gnt_rand = 1'b0;
   bit          rdy_on = 1'b1, rdy_rand = 1'b0;
   bit          lat_rand = 1'b0, hold = 1'b0;
   int          lat_fix = 1;
   bit          redir = 1'b0;
   logic [31:0] rpc = 32'd0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive this cycle's inputs, then let combinational outputs settle.
   task automatic drive();
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'd0;
      if (!hold && mq.size() != 0 && mq[0].ready <= cyc) begin
         bus.imem_rvalid_i = 1'b1;
         bus.imem_rdata_i  = mem_word(mq[0].addr);
      end
      bus.imem_gnt_i = gnt_rand ? ($urandom_range(0, 9) < 7) : gnt_on;
      bus.d_ready_i  = rdy_rand ? ($urandom_range(0, 9) < 8) : rdy_on;
      redirect       = redir;
      redirect_pc    = rpc;
      #1;
   endtask

   // Record what the coming posedge does, score any pop, then move to the next cycle.
   task automatic end_cycle();
      int r;
      if (bus.imem_rvalid_i) void'(mq.pop_front());
      if (bus.imem_req_o && bus.imem_gnt_i) begin
         r = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_fix);
         if (r <= last_ready) r = last_ready + 1;
         last_ready = r;
         mq.push_back('{addr: bus.imem_addr_o, ready: r});
      end
      if (!rst) begin
         if (bus.f_valid_o && !bus.d_ready_i) stall_tally++;
         if (redirect) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
         end else if (bus.f_valid_o && bus.d_ready_i) begin
            check("pop_pc", bus.f_pc_o, exp_pc);
            check("pop_instr", bus.f_instr_o, mem_word(exp_pc));
            exp_pc += 32'd4;
            pops++;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic tick();
      drive();
      end_cycle();
   endtask

   task automatic run_pops(input string tag, input int want, input int budget);
      int base;
      int n;
      base = pops;
      n = 0;
      while ((pops - base) < want && n < budget) begin
         tick();
         n++;
      end
      check(tag, pops - base, want);
   endtask

   task automatic do_reset(input bit clear_mem);
      rst   = 1'b1;
      redir = 1'b0;
      hold  = 1'b0;
      if (clear_mem) mq.delete();
      tick();
      drive();
      check("rst_req", bus.imem_req_o, 32'd0);
      check("rst_addr", bus.imem_addr_o, RESET_PC);
      check("rst_valid", bus.f_valid_o, 32'd0);
      check("rst_pc", bus.f_pc_o, 32'd0);
      check("rst_instr", bus.f_instr_o, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_perf_stall", perf_stall, 32'd0);
      check("rst_perf_flush", perf_flush, 32'd0);
`endif
      end_cycle();
      rst         = 1'b0;
      exp_pc      = RESET_PC;
      stall_tally = 0;
      flush_tally = 0;
   endtask

   // Two grants, one response buffered, then responses frozen: 2 in flight, 1 buffered.
   task automatic build_two_plus_one();
      gnt_on  = 1'b1;
      lat_fix = 1;
      rdy_on  = 1'b0;
      tick();
      tick();
      hold = 1'b1;
      tick();
      check("setup_out", 32'(dut.out_cnt_q), 32'd2);
      check("setup_buf", 32'(dut.rsp_cnt_q), 32'd1);
   endtask

   initial begin
      bus.imem_gnt_i    = 1'b0;
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'd0;
      bus.d_ready_i     = 1'b0;

      // Streaming with a 1-cycle memory
      do_reset(1'b1);
      gnt_on = 1'b1; rdy_on = 1'b1; lat_fix = 1;
      for (int c = 0; c < 6; c++) begin
         drive();
         check("a_req", bus.imem_req_o, 32'd1);
         check("a_addr", bus.imem_addr_o, 32'(4 * c));
         check("a_valid", bus.f_valid_o, 32'(c >= 2));
         if (c >= 2) check("a_pc", bus.f_pc_o, 32'(4 * (c - 2)));
         end_cycle();
      end

      // Decode stall fills the buffer and throttles requests
      rdy_on = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      drive();
      check("b_valid", bus.f_valid_o, 32'd1);
      check("b_req", bus.imem_req_o, 32'd0);
      check("b_buf", 32'(dut.rsp_cnt_q), 32'd3);
      check("b_out", 32'(dut.out_cnt_q), 32'd0);
      end_cycle();
      rdy_on = 1'b1;
      run_pops("b_pops", 6, 30);

      // Redirect with 2 in flight and 1 buffered, no concurrent response
      do_reset(1'b1);
      build_two_plus_one();
      redir = 1'b1; rpc = 32'h0000_0103;
      drive();
      check("c_req_redir", bus.imem_req_o, 32'd0);
      end_cycle();
      redir = 1'b0;
      flush_tally += 3;
      check("c_drop", 32'(dut.drop_cnt_q), 32'd2);
      check("c_out", 32'(dut.out_cnt_q), 32'd0);
      check("c_valid", bus.f_valid_o, 32'd0);
      hold = 1'b0; rdy_on = 1'b1;
      drive();
      check("c_req", bus.imem_req_o, 32'd1);
      check("c_addr", bus.imem_addr_o, 32'h0000_0100);
      end_cycle();
      run_pops("c_pops", 4, 30);

      // Redirect coinciding with a pop and a live response
      do_reset(1'b1);
      build_two_plus_one();
      hold = 1'b0; rdy_on = 1'b1; redir = 1'b1; rpc = 32'h0000_0200;
      drive();
      check("e_valid_pre", bus.f_valid_o, 32'd1);
      end_cycle();
      redir = 1'b0;
      flush_tally += 3;
      check("e_valid", bus.f_valid_o, 32'd0);
      check("e_out", 32'(dut.out_cnt_q), 32'd0);
      check("e_drop", 32'(dut.drop_cnt_q), 32'd1);
      run_pops("e_pops", 4, 30);

      // Variable latency, random grant and random decode back-pressure
      gnt_rand = 1'b1; lat_rand = 1'b1; rdy_rand = 1'b1;
      run_pops("d_pops", 40, 3000);
      gnt_rand = 1'b0; lat_rand = 1'b0; rdy_rand = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      check("perf_stall", perf_stall, 32'(stall_tally));
      check("perf_flush", perf_flush, 32'(flush_tally));
`endif

      // Reset mid-stream with 2 in flight; their late responses must be ignored
      do_reset(1'b1);
      gnt_on = 1'b1; rdy_on = 1'b1; lat_fix = 3;
      tick();
      tick();
      check("f_out", 32'(dut.out_cnt_q), 32'd2);
      gnt_on = 1'b0;
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) begin
         drive();
         check("f_addr", bus.imem_addr_o, RESET_PC);
         end_cycle();
         check("f_valid", bus.f_valid_o, 32'd0);
      end
      check("f_stale_done", 32'(mq.size()), 32'd0);
      check("f_out_idle", 32'(dut.out_cnt_q), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("f_perf_stall", perf_stall, 32'd0);
      check("f_perf_flush", perf_flush, 32'd0);
`endif
      gnt_on = 1'b1; lat_fix = 1;
      run_pops("f_pops", 3, 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
